// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared memory-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    // Which requester owns the in-flight access
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    // Transfer size of one doubleword, in bytes; fetches always use this
    localparam logic [3:0] XFER_DW = 4'b1000;

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Loadable down-counter that times the fixed memory latency of one access.
// Latency: load takes effect on the next edge; zero flag is combinational.
// Backpressure: none; decrements whenever enabled and saturates at zero.
module mem_arb_lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] r_cnt;

    // Load with MEM_LAT-1 when the command issues, then count down while waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(MEM_LAT - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // High when the decrement in progress brings the count to zero, so the
    // owner can leave its wait state on this same edge
    assign o_zero = (r_cnt <= CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one memory port and sequences each access.
// Latency: grant at cycle 0, command at cycle 1, rvalid at cycle 1+MEM_LAT; one access per MEM_LAT+2 cycles.
// Backpressure: requests are levels sampled only when idle; busy stalls the pipeline. Option: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_xfer_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_xfer_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must both be >= 1");
    end

    arb_state_t        r_state;
    req_id_t           r_id;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_size;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_idle;
    logic w_force_if;
    logic w_pick_d;
    logic w_pick_if;
    logic w_grant;
    logic w_cnt_zero;

    assign w_idle = (r_state == IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;

    // Count back-to-back data grants that left fetch waiting; any fetch grant
    // or a grant with fetch idle restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_pick_if || !if_req) begin
                r_starve <= '0;
            end else if (r_starve != SW'(STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    assign w_force_if = (r_starve == SW'(STARVE_MAX)) & if_req;
`else
    // Strict data priority: fetch only wins when data is not asking
    assign w_force_if = 1'b0;
`endif

    // Data beats fetch so the older instruction drains first
    assign w_pick_d  = w_idle & d_req & ~w_force_if;
    assign w_pick_if = w_idle & if_req & ~w_pick_d;
    assign w_grant   = w_pick_d | w_pick_if;

    mem_arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == CMD),
        .i_dec  (r_state == WAIT),
        .o_zero (w_cnt_zero)
    );

    // Access sequencing: grant in IDLE, one command cycle, wait out the latency, respond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_grant) r_state <= CMD;
                CMD:     r_state <= (MEM_LAT == 1) ? RESP : WAIT;
                WAIT:    if (w_cnt_zero) r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Latch the winning request; these drive the memory port until the next grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id    <= REQ_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_size  <= '0;
        end else if (w_grant) begin
            r_id    <= w_pick_d ? REQ_D : REQ_IF;
            r_addr  <= w_pick_d ? d_addr : if_addr;
            r_we    <= w_pick_d & d_we;
            r_wdata <= w_pick_d ? d_wdata : '0;
            r_size  <= w_pick_d ? d_xfer_size : XFER_DW;
        end
    end

    // Hold the last response per requester so rdata stays stable between responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (r_state == RESP) begin
            if (r_id == REQ_D) begin
                r_d_rdata <= mem_rdata;
            end else begin
                r_if_rdata <= mem_rdata;
            end
        end
    end

    // Grants are gated by reset so a request held during reset cannot leak out
    assign if_gnt = w_pick_if & rst;
    assign d_gnt  = w_pick_d & rst;

    assign mem_re        = (r_state == CMD) & ~r_we;
    assign mem_we        = (r_state == CMD) & r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_xfer_size = r_size;

    // Memory data is only valid in the response cycle, so pass it straight through then
    assign if_rvalid = (r_state == RESP) & (r_id == REQ_IF);
    assign d_rvalid  = (r_state == RESP) & (r_id == REQ_D);
    assign if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata   = d_rvalid ? mem_rdata : r_d_rdata;

    assign busy = ~w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // DUT A: MEM_LAT = 2
    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_xfer_size, mem_xfer_size;
    logic        mem_re, mem_we, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    // DUT B: MEM_LAT = 1
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [63:0] b_if_addr, b_if_rdata;
    logic        b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [63:0] b_d_addr, b_d_wdata, b_d_rdata;
    logic [3:0]  b_d_xfer_size, b_mem_xfer_size;
    logic        b_mem_re, b_mem_we, b_busy;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_xfer_size(d_xfer_size),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_xfer_size(mem_xfer_size), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_xfer_size(b_d_xfer_size),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_xfer_size(b_mem_xfer_size), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Memory contents as a pure function of address
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h40) return 64'h8B000020;
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data valid only in the cycle exactly LAT after the command
    int          a_cmd_cyc = -100;
    logic [63:0] a_cmd_addr = '0;
    int          b_cmd_cyc = -100;
    logic [63:0] b_cmd_addr = '0;
    always @(posedge clk) begin
        if (mem_re | mem_we) begin a_cmd_cyc <= cyc; a_cmd_addr <= mem_addr; end
        if (b_mem_re | b_mem_we) begin b_cmd_cyc <= cyc; b_cmd_addr <= b_mem_addr; end
    end
    assign mem_rdata   = (cyc == a_cmd_cyc + LAT) ? mem_fn(a_cmd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    assign b_mem_rdata = (cyc == b_cmd_cyc + 1)   ? mem_fn(b_cmd_addr) : 64'hBAD1_BAD1_BAD1_BAD1;

    // Scoreboard: expected responses in grant order
    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [63:0] dat;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        if (rst) begin
            check_eq("excl", {61'd0, if_gnt & d_gnt, if_rvalid & d_rvalid, mem_re & mem_we}, 64'd0);
            if (if_rvalid | d_rvalid) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check_eq("sb_who", {63'd0, d_rvalid}, {63'd0, sb_e.is_d});
                    if (sb_e.chk) check_eq("sb_data", sb_e.is_d ? d_rdata : if_rdata, sb_e.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  n_ev;
    int  waited;
    logic exp_d;

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_xfer_size = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0; b_d_xfer_size = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ctl", {53'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we, busy, mem_xfer_size}, 64'd0);
        check_eq("rst_dat", if_rdata | d_rdata | mem_addr | mem_wdata, 64'd0);
        check_eq("rst_ctl_b", {61'd0, b_busy, b_mem_re, b_d_rvalid}, 64'd0);
        tick(); rst = 1'b1;

        // Single fetch from 0x40
        tick(); if_req = 1; if_addr = 64'h40;
        sb_q.push_back(exp_t'({1'b0, 1'b1, 64'h8B000020}));
        @(negedge clk); check_eq("f_gnt", {62'd0, if_gnt, d_gnt}, 64'b10); check_eq("f_busy_c0", busy, 0);
        tick(); if_req = 0; if_addr = 64'h999;
        @(negedge clk); check_eq("f_cmd", {62'd0, mem_re, mem_we}, 64'b10); check_eq("f_addr", mem_addr, 64'h40);
        @(negedge clk); check_eq("f_rv_c2", if_rvalid, 0);
        @(negedge clk); check_eq("f_rv_c3", if_rvalid, 1); check_eq("f_rdata", if_rdata, 64'h8B000020);
        @(negedge clk); check_eq("f_busy_c4", busy, 0); check_eq("f_rdata_hold", if_rdata, 64'h8B000020);

        // Simultaneous fetch and load: data first
        tick(); d_req = 1; d_we = 0; d_addr = 64'h100; d_xfer_size = XFER_DW; if_req = 1; if_addr = 64'h80;
        sb_q.push_back(exp_t'({1'b1, 1'b1, mem_fn(64'h100)}));
        sb_q.push_back(exp_t'({1'b0, 1'b1, mem_fn(64'h80)}));
        @(negedge clk); check_eq("s_gnt_c0", {62'd0, if_gnt, d_gnt}, 64'b01);
        tick(); d_req = 0;
        repeat (3) @(negedge clk); check_eq("s_drv_c3", d_rvalid, 1);
        @(negedge clk); check_eq("s_gnt_c4", {62'd0, if_gnt, d_gnt}, 64'b10);
        tick(); if_req = 0;
        @(negedge clk); check_eq("s_addr_c5", mem_addr, 64'h80);
        repeat (2) @(negedge clk); check_eq("s_irv_c7", if_rvalid, 1);
        @(negedge clk);

        // Store: address/data changes after grant must not disturb it
        tick(); d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'hDEAD; d_xfer_size = 4'd8;
        sb_q.push_back(exp_t'({1'b1, 1'b0, 64'd0}));
        @(negedge clk); check_eq("st_gnt", d_gnt, 1);
        tick(); d_req = 0; d_we = 0; d_addr = 64'h999; d_wdata = 64'h0;
        @(negedge clk);
        check_eq("st_cmd", {62'd0, mem_we, mem_re}, 64'b10);
        check_eq("st_wdata", mem_wdata, 64'hDEAD);
        check_eq("st_size", mem_xfer_size, 64'd8);
        check_eq("st_addr", mem_addr, 64'h200);
        repeat (2) @(negedge clk); check_eq("st_ack_c3", d_rvalid, 1);
        @(negedge clk);

        // Fetch request raised and dropped while busy: never granted
        tick(); d_req = 1; d_addr = 64'h180; sb_q.push_back(exp_t'({1'b1, 1'b1, mem_fn(64'h180)}));
        @(negedge clk);
        tick(); d_req = 0; if_req = 1; if_addr = 64'h1C0;
        tick(); if_req = 0;
        n_ev = 0;
        repeat (6) begin @(negedge clk); if (if_gnt) n_ev++; end
        check_eq("drop_no_gnt", n_ev, 0);

        // Reset in the middle of a read
        tick(); if_req = 1; if_addr = 64'h60; sb_q.push_back(exp_t'({1'b0, 1'b1, mem_fn(64'h60)}));
        @(negedge clk); check_eq("rr_gnt", if_gnt, 1);
        tick(); if_req = 0;
        tick(); check_eq("rr_busy_wait", busy, 1);
        rst = 1'b0; #1;
        check_eq("rr_ctl", {53'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we, busy, mem_xfer_size}, 64'd0);
        check_eq("rr_dat", if_rdata | d_rdata | mem_addr | mem_wdata, 64'd0);
        sb_q.delete();
        tick(); rst = 1'b1;
        @(negedge clk); check_eq("rr_idle", busy, 0);
        n_ev = 0;
        repeat (6) begin @(negedge clk); if (if_rvalid | d_rvalid) n_ev++; end
        check_eq("rr_no_late_rvalid", n_ev, 0);

        // Continuous fetch + load: starvation behaviour
        tick(); d_req = 1; d_we = 0; d_addr = 64'h300; if_req = 1; if_addr = 64'h380;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_d = ((i % 5) != 4);
`else
            exp_d = 1'b1;
`endif
            sb_q.push_back(exp_t'({exp_d, 1'b1, mem_fn(exp_d ? 64'h300 : 64'h380)}));
        end
        for (int g = 0; g < 10; g++) begin
            waited = 0;
            do begin @(negedge clk); waited++; end while (!(if_gnt | d_gnt) && waited < 20);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_d = ((g % 5) != 4);
`else
            exp_d = 1'b1;
`endif
            check_eq("starve_gnt", {62'd0, if_gnt, d_gnt}, {62'd0, ~exp_d, exp_d});
        end
        tick(); d_req = 0; if_req = 0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin @(negedge clk); waited++; end
        check_eq("sb_drain", sb_q.size(), 0);

        // MEM_LAT = 1: load returns at cycle 2
        tick(); b_d_req = 1; b_d_addr = 64'h500; b_d_xfer_size = XFER_DW;
        @(negedge clk); check_eq("l1_gnt", b_d_gnt, 1);
        tick(); b_d_req = 0;
        @(negedge clk); check_eq("l1_cmd", {62'd0, b_mem_re, b_d_rvalid}, 64'b10);
        @(negedge clk); check_eq("l1_rv_c2", b_d_rvalid, 1); check_eq("l1_rdata", b_d_rdata, mem_fn(64'h500));
        @(negedge clk); check_eq("l1_busy_c3", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single shared memory port serving two requesters: the instruction-fetch stage and the load/store (MEM) stage of the pipelined CPU. It grants one access at a time and drives the memory command for one cycle. It waits a fixed memory latency, then returns read data or a write acknowledge to the granted requester. It sits between the fetch/MEM pipeline stages and the unified memory, and its `busy` output feeds the stall logic.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width
- `MEM_LAT`, 2, cycles from command cycle to `mem_rdata` valid; must be ≥1
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (only with guard enabled)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request, level
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  one-cycle grant pulse to fetch
- `if_rvalid`  out  1  one-cycle fetch data-valid pulse
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request, level
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_xfer_size`  in  4  transfer size in bytes
- `d_gnt`  out  1  one-cycle grant pulse to data
- `d_rvalid`  out  1  one-cycle load data / store ack pulse
- `d_rdata`  out  DATA_W  load data
- `mem_re`, `mem_we`  out  1  memory read/write command, one cycle each
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_xfer_size`  out  4  memory transfer size
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  access in flight (state ≠ IDLE)

## Operation
- States: IDLE, CMD, WAIT, RESP.
- IDLE: requests are sampled only in this state. With any request pending: pulse the matching `*_gnt`, latch the requester ID, address, `we`, wdata and size, and go to CMD. With no request, stay.
- Priority: data over fetch, because the older instruction must drain.
- CMD: drive `mem_re` (fetch, or data load) or `mem_we` (data store) for exactly one cycle from the latched registers. Load the latency counter with `MEM_LAT-1` and go to WAIT. If `MEM_LAT`=1, skip WAIT and go directly to RESP.
- WAIT: decrement the counter. At zero, go to RESP.
- RESP: capture `mem_rdata` into the granted requester's rdata register and pulse its `*_rvalid` (stores also pulse, as an ack). Return to IDLE.
- Counter width: `$clog2(MEM_LAT+1)`.
- Request dropped before a grant: ignored, no access issued.
- Request changes after a grant: no effect on the in-flight access.
- `mem_addr`, `mem_wdata` and `mem_xfer_size` hold their latched values until the next grant.
- `*_rdata` holds its value until the next response to the same requester.

## Timing
- Reset (`rst`=0, any time, including mid-access): state IDLE, starvation counter 0, in-flight access abandoned. All outputs are 0 and no late `*_rvalid` is produced.
- Grant at cycle 0, command at cycle 1, rvalid at cycle 1+`MEM_LAT`, next possible grant at cycle 2+`MEM_LAT`.
- Access period: `MEM_LAT`+2 cycles.
- At most one `*_gnt` and at most one `*_rvalid` are high in any cycle. `mem_re` and `mem_we` are never high together.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- Defined: a counter tracks consecutive data grants issued while `if_req` is high. When it reaches `STARVE_MAX`, the next IDLE grant goes to fetch if `if_req` is high. The counter clears on any fetch grant, or whenever `if_req` is low at a grant.
- Undefined: strict data priority. The counter logic is absent, and fetch can starve indefinitely under a continuous `d_req`.

## Structure
- Package `mem_arb_pkg`: state enum typedef (IDLE, CMD, WAIT, RESP), requester-ID enum (REQ_IF, REQ_D), and the transfer-size constant for a doubleword (4'b1000).
- One sub-module, `mem_arb_lat_counter`: loadable down-counter with a zero flag, parameterised by `MEM_LAT`.

## Test plan
All scenarios use `MEM_LAT`=2 unless stated otherwise.
- Reset mid-read: assert `rst`=0 during WAIT. Required: all outputs 0 immediately; after release, no `if_rvalid`/`d_rvalid` and state is IDLE.
- Single fetch, `if_addr`=0x40, memory returns 0x8B000020. Required: `if_gnt` at cycle 0; `mem_re`=1 with `mem_addr`=0x40 at cycle 1; `if_rvalid`=1 with `if_rdata`=0x8B000020 at cycle 3; `busy` low at cycle 4.
- Simultaneous `if_req` and `d_req` (load 0x100). Required: `d_gnt` at cycle 0, `d_rvalid` at cycle 3; `if_gnt` at cycle 4 and `if_rvalid` at cycle 7.
- Store: `d_we`=1, addr 0x200, wdata 0xDEAD, size 8. Required: at cycle 1, `mem_we`=1, `mem_wdata`=0xDEAD, `mem_xfer_size`=8 and `mem_re`=0; `d_rvalid` ack at cycle 3.
- Starvation, guard defined, `STARVE_MAX`=4: hold `d_req` and `if_req` high. Required grant order D,D,D,D,I,D,D,D,D,I. With the macro undefined, `if_gnt` never asserts.
- `MEM_LAT`=1: a single load returns `d_rvalid` at cycle 2, with no WAIT state visited.
